rx_frame_ctrl: RTL

Sequencing controller for the digital receive chain (frame sync → descrambler → Hamming decoder → 8-to-32 FIFO). It arms a reception with a start pulse and supervises the frame, and recovers from decode errors and stalled frames with a cycle timeout. After each good frame it drains exactly the announced number of 32-bit words from the receive FIFO onto a valid/ready word stream, flagging the last word. It sits between the receive datapath and the host-side consumer (DMA / AXI-stream bridge).

---
 rtl/rx_ctrl_pkg.sv | 18 +
 rtl/rx_frame_ctrl_sat_counter.sv | 19 +
 rtl/rx_frame_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/rx_ctrl_pkg.sv
// Shared types and widths for the receive-chain sequencing controller.
package rx_ctrl_pkg;

    localparam int COUNTER_W = 16;
    localparam int LEN_W     = 8;
    localparam int TO_W      = 24;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_RD    = 3'd3,
        S_LAT   = 3'd4,
        S_OUT   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/rx_frame_ctrl_sat_counter.sv
// Event counter that increments by one when inc is high and holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Arms receptions, supervises frames with a timeout, then drains len words one at a time.
// Word period is 2+RD_LATENCY cycles; a word stays held on the output while ready is low.
module rx_frame_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 24'd10_000_000,
    parameter int              RD_LATENCY  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic                 i_abort,
    output logic                 o_rx_start_pulse,
    input  logic                 i_rx_end_pulse,
    input  logic                 i_error_pulse,
    input  logic [31:0]          i_data_num,
    output logic                 o_rx_rd_pulse,
    input  logic [31:0]          i_rx_data,
    output logic [31:0]          o_word_data,
    output logic                 o_word_valid,
    input  logic                 i_word_ready,
    output logic                 o_word_last,
    output logic                 o_frame_done_pulse,
    output logic [LEN_W-1:0]     o_frame_len,
    output logic [COUNTER_W-1:0] o_frame_cnt,
    output logic [COUNTER_W-1:0] o_err_cnt,
    output logic [COUNTER_W-1:0] o_timeout_cnt,
    output logic                 o_busy
);

    state_t           state;
    state_t           state_nxt;
    state_t           rearm;
    logic [TO_W-1:0]  to_cnt;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       lat_cnt;
    logic             lat_done;
    logic             to_hit;
    logic             accept;
    logic             latch_len;
    logic             capture;
    logic             err_inc;
    logic             to_inc;
    logic             frame_inc;
    logic             data_num_unused;

    assign data_num_unused = ^i_data_num[31:LEN_W];
    assign lat_done = (lat_cnt == 2'(RD_LATENCY - 1));
    assign to_hit   = (to_cnt == TIMEOUT_CYC - 24'd1);
    assign rearm    = i_enable ? S_START : S_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        latch_len = 1'b0;
        capture   = 1'b0;
        err_inc   = 1'b0;
        to_inc    = 1'b0;
        frame_inc = 1'b0;
        if (i_abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (i_enable) state_nxt = S_START;
                S_START: state_nxt = S_WAIT;
                S_WAIT: begin
                    // error outranks a coincident end pulse
                    if (i_error_pulse) begin
                        err_inc   = 1'b1;
                        state_nxt = rearm;
                    end else if (i_rx_end_pulse) begin
                        latch_len = 1'b1;
                        state_nxt = (i_data_num[LEN_W-1:0] == '0) ? S_DONE : S_RD;
                    end else if (to_hit) begin
                        to_inc    = 1'b1;
                        state_nxt = rearm;
                    end
                end
                S_RD:    state_nxt = S_LAT;
                S_LAT: begin
                    if (lat_done) begin
                        capture   = 1'b1;
                        state_nxt = S_OUT;
                    end
                end
                S_OUT: begin
                    if (o_word_valid && i_word_ready) begin
                        accept    = 1'b1;
                        state_nxt = (remaining == 8'd1) ? S_DONE : S_RD;
                    end
                end
                S_DONE: begin
                    frame_inc = 1'b1;
                    state_nxt = rearm;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt             <= '0;
            lat_cnt            <= '0;
            remaining          <= '0;
            o_frame_len        <= '0;
            o_word_data        <= '0;
            o_rx_start_pulse   <= 1'b0;
            o_rx_rd_pulse      <= 1'b0;
            o_frame_done_pulse <= 1'b0;
            o_word_valid       <= 1'b0;
            o_word_last        <= 1'b0;
            o_busy             <= 1'b0;
        end else begin
            if (state == S_START) begin
                to_cnt <= '0;
            end else if (state == S_WAIT) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state == S_RD) begin
                lat_cnt <= '0;
            end else if ((state == S_LAT) && !lat_done) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (latch_len) begin
                o_frame_len <= i_data_num[LEN_W-1:0];
                remaining   <= i_data_num[LEN_W-1:0];
            end else if (accept) begin
                remaining <= remaining - 1'b1;
            end
            if (capture) begin
                o_word_data <= i_rx_data;
            end
            o_rx_start_pulse   <= (state_nxt == S_START);
            o_rx_rd_pulse      <= (state_nxt == S_RD);
            o_frame_done_pulse <= (state_nxt == S_DONE);
            o_word_valid       <= (state_nxt == S_OUT);
            o_word_last        <= (state_nxt == S_OUT) && (remaining == 8'd1);
            o_busy             <= (state_nxt != S_IDLE);
        end
    end

    sat_counter #(.WIDTH(COUNTER_W)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (frame_inc),
        .count (o_frame_cnt)
    );

    sat_counter #(.WIDTH(COUNTER_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .count (o_err_cnt)
    );

    sat_counter #(.WIDTH(COUNTER_W)) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (to_inc),
        .count (o_timeout_cnt)
    );

endmodule
